// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite crossbar types: response codes, FSM state encodings, default address map.
// Pure declarations: no latency, no backpressure.
package axi_lite_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    localparam logic [31:0] SRAM_BASE = 32'h8000_0000;
    localparam logic [31:0] SRAM_SIZE = 32'h0800_0000;
    localparam logic [31:0] UART_BASE = 32'ha000_03f8;
    localparam logic [31:0] UART_SIZE = 32'h0000_0008;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP,
        W_BACK
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_RESP,
        R_BACK
    } rstate_e;

endpackage

// File: rtl/axi_lite_xbar_if.sv
// AXI4-Lite channel bundle; master modport drives requests, slave modport answers them.
// Wires only: no latency, valid/ready backpressure on every channel.
interface axi_lite_xbar_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_decode.sv
// Address decoder returning {hit0, hit1}; windows use wrapping offset compare.
// Combinational, zero latency, no backpressure.
module axi_lite_decode
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE0 = SRAM_BASE,
    parameter logic [31:0] SIZE0 = SRAM_SIZE,
    parameter logic [31:0] BASE1 = UART_BASE,
    parameter logic [31:0] SIZE1 = UART_SIZE
) (
    input  logic [31:0] i_addr,
    output logic [1:0]  o_hit
);

    logic [31:0] w_off0;
    logic [31:0] w_off1;

    // Addresses below a base wrap to a huge offset and therefore miss.
    assign w_off0 = i_addr - BASE0;
    assign w_off1 = i_addr - BASE1;
    assign o_hit  = {w_off0 < SIZE0, w_off1 < SIZE1};

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-master/2-slave AXI4-Lite crossbar (s0 SRAM, s1 UART), DECERR for unmapped addresses.
// Latency 3 cycles handshake-to-response (1 for DECERR); one outstanding op per direction, responses held until master ready.
module axi_lite_xbar
    import axi_lite_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    axi_lite_xbar_if.slave  m,
    axi_lite_xbar_if.master s0,
    axi_lite_xbar_if.master s1
);

    // ---------------- write path ----------------
    wstate_e     r_wstate, w_wstate_nxt;
    logic        r_aw_got, r_w_got, r_aw_done, r_w_done, r_wsel;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;

    logic        w_aw_hs, w_w_hs, w_saw_hs, w_sw_hs;
    logic        w_m_awready, w_m_wready, w_m_bvalid;
    logic        w_s_awvalid, w_s_wvalid, w_s_bready;
    logic        w_s_awready, w_s_wready, w_s_bvalid;
    logic [1:0]  w_s_bresp;
    logic [31:0] w_wdec_addr;
    logic [1:0]  w_whit;

    assign w_s_awready = r_wsel ? s1.awready : s0.awready;
    assign w_s_wready  = r_wsel ? s1.wready  : s0.wready;
    assign w_s_bvalid  = r_wsel ? s1.bvalid  : s0.bvalid;
    assign w_s_bresp   = r_wsel ? s1.bresp   : s0.bresp;

    assign w_aw_hs  = m.awvalid && (r_wstate == W_IDLE) && !r_aw_got;
    assign w_w_hs   = m.wvalid  && (r_wstate == W_IDLE) && !r_w_got;
    assign w_saw_hs = w_s_awready && (r_wstate == W_REQ) && !r_aw_done;
    assign w_sw_hs  = w_s_wready  && (r_wstate == W_REQ) && !r_w_done;

    // Decode the address arriving this cycle so the hit is known when W completes the pair.
    assign w_wdec_addr = r_aw_got ? r_awaddr : m.awaddr;

    axi_lite_decode u_wdec (.i_addr(w_wdec_addr), .o_hit(w_whit));

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_m_awready  = 1'b0;
        w_m_wready   = 1'b0;
        w_m_bvalid   = 1'b0;
        w_s_awvalid  = 1'b0;
        w_s_wvalid   = 1'b0;
        w_s_bready   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_m_awready = !r_aw_got;
                w_m_wready  = !r_w_got;
                if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs))
                    w_wstate_nxt = (|w_whit) ? W_REQ : W_BACK;
            end
            W_REQ: begin
                w_s_awvalid = !r_aw_done;
                w_s_wvalid  = !r_w_done;
                if ((r_aw_done || w_saw_hs) && (r_w_done || w_sw_hs))
                    w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_s_bready = 1'b1;
                if (w_s_bvalid)
                    w_wstate_nxt = W_BACK;
            end
            W_BACK: begin
                w_m_bvalid = 1'b1;
                if (m.bready)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wsel    <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= m.awaddr;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= m.wdata;
                r_wstrb <= m.wstrb;
            end
            if (r_wstate == W_IDLE && w_wstate_nxt != W_IDLE) begin
                r_wsel    <= w_whit[0];
                r_bresp   <= (|w_whit) ? RESP_OKAY : RESP_DECERR;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_saw_hs)
                r_aw_done <= 1'b1;
            if (w_sw_hs)
                r_w_done <= 1'b1;
            if (r_wstate == W_RESP && w_s_bvalid)
                r_bresp <= w_s_bresp;
            if (r_wstate == W_BACK && m.bready) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    rstate_e     r_rstate, w_rstate_nxt;
    logic        r_rsel;
    logic [31:0] r_araddr, r_rdata;
    logic [1:0]  r_rresp;

    logic        w_ar_hs, w_m_arready, w_m_rvalid, w_s_arvalid, w_s_rready;
    logic        w_s_arready, w_s_rvalid;
    logic [31:0] w_s_rdata;
    logic [1:0]  w_s_rresp;
    logic [1:0]  w_rhit;

    assign w_s_arready = r_rsel ? s1.arready : s0.arready;
    assign w_s_rvalid  = r_rsel ? s1.rvalid  : s0.rvalid;
    assign w_s_rdata   = r_rsel ? s1.rdata   : s0.rdata;
    assign w_s_rresp   = r_rsel ? s1.rresp   : s0.rresp;
    assign w_ar_hs     = m.arvalid && (r_rstate == R_IDLE);

    axi_lite_decode u_rdec (.i_addr(m.araddr), .o_hit(w_rhit));

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_m_arready  = 1'b0;
        w_m_rvalid   = 1'b0;
        w_s_arvalid  = 1'b0;
        w_s_rready   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_m_arready = 1'b1;
                if (m.arvalid)
                    w_rstate_nxt = (|w_rhit) ? R_REQ : R_BACK;
            end
            R_REQ: begin
                w_s_arvalid = 1'b1;
                if (w_s_arready)
                    w_rstate_nxt = R_RESP;
            end
            R_RESP: begin
                w_s_rready = 1'b1;
                if (w_s_rvalid)
                    w_rstate_nxt = R_BACK;
            end
            R_BACK: begin
                w_m_rvalid = 1'b1;
                if (m.rready)
                    w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsel   <= 1'b0;
            r_araddr <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_araddr <= m.araddr;
                r_rsel   <= w_rhit[0];
                if (!(|w_rhit)) begin
                    r_rresp <= RESP_DECERR;
                    r_rdata <= '0;
                end
            end
            if (r_rstate == R_RESP && w_s_rvalid) begin
                r_rdata <= w_s_rdata;
                r_rresp <= w_s_rresp;
            end
        end
    end

    // ---------------- port wiring ----------------
    assign m.awready = w_m_awready;
    assign m.wready  = w_m_wready;
    assign m.bvalid  = w_m_bvalid;
    assign m.bresp   = r_bresp;
    assign m.arready = w_m_arready;
    assign m.rvalid  = w_m_rvalid;
    assign m.rdata   = r_rdata;
    assign m.rresp   = r_rresp;

    assign s0.awvalid = w_s_awvalid && !r_wsel;
    assign s1.awvalid = w_s_awvalid &&  r_wsel;
    assign s0.wvalid  = w_s_wvalid  && !r_wsel;
    assign s1.wvalid  = w_s_wvalid  &&  r_wsel;
    assign s0.bready  = w_s_bready  && !r_wsel;
    assign s1.bready  = w_s_bready  &&  r_wsel;
    assign s0.arvalid = w_s_arvalid && !r_rsel;
    assign s1.arvalid = w_s_arvalid &&  r_rsel;
    assign s0.rready  = w_s_rready  && !r_rsel;
    assign s1.rready  = w_s_rready  &&  r_rsel;

    assign s0.awaddr = r_awaddr;
    assign s1.awaddr = r_awaddr;
    assign s0.wdata  = r_wdata;
    assign s1.wdata  = r_wdata;
    assign s0.wstrb  = r_wstrb;
    assign s1.wstrb  = r_wstrb;
    assign s0.araddr = r_araddr;
    assign s1.araddr = r_araddr;

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: behavioural SRAM/UART slaves plus cycle-exact master vectors.
module tb_axi_lite_xbar;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_xbar_if m_if ();
    axi_lite_xbar_if s0_if ();
    axi_lite_xbar_if s1_if ();

    axi_lite_xbar dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m     (m_if),
        .s0    (s0_if),
        .s1    (s1_if)
    );

    // Slave-side view as two-entry arrays so one model serves both slaves.
    logic [1:0]  sl_awvalid, sl_wvalid, sl_arvalid, sl_bready, sl_rready;
    logic [31:0] sl_awaddr [2];
    logic [31:0] sl_wdata  [2];
    logic [31:0] sl_araddr [2];
    logic [3:0]  sl_wstrb  [2];
    logic [1:0]  sl_arready, sl_bvalid, sl_rvalid;
    logic [31:0] sl_rdata  [2];

    assign sl_awvalid = {s1_if.awvalid, s0_if.awvalid};
    assign sl_wvalid  = {s1_if.wvalid,  s0_if.wvalid};
    assign sl_arvalid = {s1_if.arvalid, s0_if.arvalid};
    assign sl_bready  = {s1_if.bready,  s0_if.bready};
    assign sl_rready  = {s1_if.rready,  s0_if.rready};
    assign sl_awaddr[0] = s0_if.awaddr;  assign sl_awaddr[1] = s1_if.awaddr;
    assign sl_wdata[0]  = s0_if.wdata;   assign sl_wdata[1]  = s1_if.wdata;
    assign sl_wstrb[0]  = s0_if.wstrb;   assign sl_wstrb[1]  = s1_if.wstrb;
    assign sl_araddr[0] = s0_if.araddr;  assign sl_araddr[1] = s1_if.araddr;

    assign s0_if.awready = 1'b1;          assign s1_if.awready = 1'b1;
    assign s0_if.wready  = 1'b1;          assign s1_if.wready  = 1'b1;
    assign s0_if.bresp   = 2'b00;         assign s1_if.bresp   = 2'b00;
    assign s0_if.rresp   = 2'b00;         assign s1_if.rresp   = 2'b00;
    assign s0_if.bvalid  = sl_bvalid[0];  assign s1_if.bvalid  = sl_bvalid[1];
    assign s0_if.arready = sl_arready[0]; assign s1_if.arready = sl_arready[1];
    assign s0_if.rvalid  = sl_rvalid[0];  assign s1_if.rvalid  = sl_rvalid[1];
    assign s0_if.rdata   = sl_rdata[0];   assign s1_if.rdata   = sl_rdata[1];

    logic [1:0]  aw_seen, w_seen;
    logic [1:0]  b_hold;
    int          cfg_stall [2];
    logic [31:0] cfg_rdata [2];
    int          st_cnt    [2];
    int          aw_cnt  [2] = '{0, 0};
    int          w_cnt   [2] = '{0, 0};
    int          ar_cnt  [2] = '{0, 0};
    int          vld_cyc [2] = '{0, 0};
    logic [31:0] log_awaddr [2];
    logic [31:0] log_wdata  [2];
    logic [31:0] log_araddr [2];
    logic [3:0]  log_wstrb  [2];

    // Slaves accept AW/W immediately, answer B one cycle after both, stall AR cfg_stall cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_arready <= '0;
            sl_bvalid  <= '0;
            sl_rvalid  <= '0;
            aw_seen    <= '0;
            w_seen     <= '0;
            for (int i = 0; i < 2; i++) begin
                st_cnt[i]   <= 0;
                sl_rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sl_awvalid[i] || sl_wvalid[i] || sl_arvalid[i])
                    vld_cyc[i] <= vld_cyc[i] + 1;
                if (sl_awvalid[i]) begin
                    aw_cnt[i]     <= aw_cnt[i] + 1;
                    log_awaddr[i] <= sl_awaddr[i];
                end
                if (sl_wvalid[i]) begin
                    w_cnt[i]     <= w_cnt[i] + 1;
                    log_wdata[i] <= sl_wdata[i];
                    log_wstrb[i] <= sl_wstrb[i];
                end
                if (sl_bvalid[i] && sl_bready[i])
                    sl_bvalid[i] <= 1'b0;
                if ((aw_seen[i] || sl_awvalid[i]) && (w_seen[i] || sl_wvalid[i]) && !b_hold[i]) begin
                    sl_bvalid[i] <= 1'b1;
                    aw_seen[i]   <= 1'b0;
                    w_seen[i]    <= 1'b0;
                end else begin
                    if (sl_awvalid[i]) aw_seen[i] <= 1'b1;
                    if (sl_wvalid[i])  w_seen[i]  <= 1'b1;
                end
                if (sl_rvalid[i] && sl_rready[i])
                    sl_rvalid[i] <= 1'b0;
                if (sl_arvalid[i] && sl_arready[i]) begin
                    ar_cnt[i]     <= ar_cnt[i] + 1;
                    log_araddr[i] <= sl_araddr[i];
                    sl_arready[i] <= (cfg_stall[i] == 0);
                    st_cnt[i]     <= 0;
                    sl_rvalid[i]  <= 1'b1;
                    sl_rdata[i]   <= cfg_rdata[i];
                end else if (sl_arvalid[i]) begin
                    if (st_cnt[i] + 1 >= cfg_stall[i])
                        sl_arready[i] <= 1'b1;
                    st_cnt[i] <= st_cnt[i] + 1;
                end else begin
                    sl_arready[i] <= (cfg_stall[i] == 0);
                end
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called one cycle after the handshake edge; returns the cycle index where valid is seen.
    task automatic wait_b(input int max, output int n);
        n = 1;
        while (!m_if.bvalid && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_r(input int max, output int n);
        n = 1;
        while (!m_if.rvalid && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "simulation hung");
    end

    initial begin
        int lat, pulses, rcyc, bstable;
        int snap0, snap1, snap2;
        logic [33:0] rdat;

        m_if.awaddr = '0; m_if.awvalid = 1'b0;
        m_if.wdata = '0;  m_if.wstrb = '0; m_if.wvalid = 1'b0;
        m_if.araddr = '0; m_if.arvalid = 1'b0;
        m_if.bready = 1'b1; m_if.rready = 1'b1;
        cfg_stall[0] = 0; cfg_stall[1] = 0;
        cfg_rdata[0] = '0; cfg_rdata[1] = '0;
        b_hold = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_m_rdy", {m_if.awready, m_if.wready, m_if.arready}, 3'b111);
        chk("rst_m_vld", {m_if.bvalid, m_if.rvalid}, 2'b00);
        chk("rst_m_resp", {m_if.bresp, m_if.rresp, m_if.rdata}, 36'h0);
        chk("rst_s_hs", {sl_awvalid, sl_wvalid, sl_arvalid, sl_bready, sl_rready}, 10'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: UART write, AW and W together
        snap0 = vld_cyc[0]; snap1 = aw_cnt[1];
        m_if.awaddr = 32'ha000_03f8; m_if.wdata = 32'h41; m_if.wstrb = 4'hf;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        chk("t1_s1_vld", {sl_awvalid[1], sl_wvalid[1]}, 2'b11);
        chk("t1_s0_vld", {sl_awvalid[0], sl_wvalid[0]}, 2'b00);
        chk("t1_s1_dat", {s1_if.awaddr, s1_if.wdata}, {32'ha000_03f8, 32'h41});
        wait_b(20, lat);
        chk("t1_lat", lat, 3);
        chk("t1_bresp", {m_if.bvalid, m_if.bresp}, 3'b100);
        @(negedge clk);
        chk("t1_b_drop", m_if.bvalid, 0);
        chk("t1_s0_idle", vld_cyc[0] - snap0, 0);
        chk("t1_s1_aw", aw_cnt[1] - snap1, 1);

        // T2: W two cycles ahead of AW, SRAM
        snap0 = aw_cnt[0]; snap1 = w_cnt[0]; snap2 = vld_cyc[1];
        m_if.wdata = 32'hcafe_f00d; m_if.wstrb = 4'b0110; m_if.wvalid = 1'b1;
        @(negedge clk);
        m_if.wvalid = 1'b0;
        chk("t2_w_held", {m_if.wready, m_if.awready}, 2'b01);
        @(negedge clk);
        m_if.awaddr = 32'h8000_0010; m_if.awvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0;
        pulses = 0;
        repeat (10) begin
            if (m_if.bvalid) pulses++;
            @(negedge clk);
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_s0_cnt", {aw_cnt[0] - snap0, w_cnt[0] - snap1}, {32'd1, 32'd1});
        chk("t2_s0_addr", log_awaddr[0], 32'h8000_0010);
        chk("t2_s0_dat", {log_wstrb[0], log_wdata[0]}, {4'b0110, 32'hcafe_f00d});
        chk("t2_s1_idle", vld_cyc[1] - snap2, 0);

        // T3: SRAM read, arready stalled two cycles
        cfg_stall[0] = 2; cfg_rdata[0] = 32'hdead_beef;
        @(negedge clk);
        m_if.araddr = 32'h8000_0000; m_if.arvalid = 1'b1;
        @(negedge clk);
        m_if.arvalid = 1'b0;
        chk("t3_s0_ar", {sl_arvalid[0], sl_arready[0], sl_arvalid[1]}, 3'b100);
        wait_r(20, lat);
        chk("t3_lat", lat, 5);
        chk("t3_rdata", {m_if.rresp, m_if.rdata}, {2'b00, 32'hdead_beef});
        @(negedge clk);
        chk("t3_r_drop", m_if.rvalid, 0);
        cfg_stall[0] = 0;

        // T4: unmapped write and read
        snap0 = vld_cyc[0]; snap1 = vld_cyc[1];
        m_if.awaddr = 32'h0000_0000; m_if.wdata = 32'hffff_ffff; m_if.wstrb = 4'hf;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        chk("t4_b", {m_if.bvalid, m_if.bresp}, 3'b111);
        @(negedge clk);
        m_if.araddr = 32'hffff_fffc; m_if.arvalid = 1'b1;
        @(negedge clk);
        m_if.arvalid = 1'b0;
        chk("t4_r", {m_if.rvalid, m_if.rresp, m_if.rdata}, {1'b1, 2'b11, 32'h0});
        @(negedge clk);
        chk("t4_no_slave", {vld_cyc[0] - snap0, vld_cyc[1] - snap1}, 64'h0);

        // T5: UART read alongside SRAM write with bready held low
        cfg_rdata[1] = 32'h5a;
        m_if.bready = 1'b0;
        m_if.awaddr = 32'h8000_0020; m_if.wdata = 32'h1234_5678; m_if.wstrb = 4'hf;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        m_if.araddr = 32'ha000_03fc; m_if.arvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0; m_if.arvalid = 1'b0;
        rcyc = 0; bstable = 0; rdat = '0;
        for (int k = 1; k <= 7; k++) begin
            if (m_if.rvalid && rcyc == 0) begin
                rcyc = k;
                rdat = {m_if.rresp, m_if.rdata};
            end
            if (m_if.bvalid && m_if.bresp == 2'b00) bstable++;
            if (k < 7) @(negedge clk);
        end
        m_if.bready = 1'b1;
        @(negedge clk);
        chk("t5_rcyc", rcyc, 3);
        chk("t5_rdata", rdat, {2'b00, 32'h5a});
        chk("t5_s1_araddr", log_araddr[1], 32'ha000_03fc);
        chk("t5_bhold", bstable, 5);
        chk("t5_b_rel", m_if.bvalid, 0);

        // T6: reset while waiting on the slave response
        b_hold = 2'b01;
        m_if.awaddr = 32'h8000_0040; m_if.wdata = 32'h1; m_if.wstrb = 4'hf;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_in_resp", {sl_bready[0], m_if.awready, m_if.bvalid}, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", {sl_awvalid, sl_wvalid, sl_arvalid, sl_bready, sl_rready,
                           m_if.bvalid, m_if.rvalid}, 12'h0);
        b_hold = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rdy", {m_if.awready, m_if.wready, m_if.arready}, 3'b111);
        @(negedge clk);
        snap1 = aw_cnt[1];
        m_if.awaddr = 32'ha000_03f8; m_if.wdata = 32'h42; m_if.wstrb = 4'h1;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        @(negedge clk);
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        wait_b(20, lat);
        chk("t6_lat", lat, 3);
        chk("t6_bresp", {m_if.bvalid, m_if.bresp}, 3'b100);
        chk("t6_s1_dat", {aw_cnt[1] - snap1, log_wdata[1]}, {32'd1, 32'h42});
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_xbar.md
# axi_lite_xbar

Single-master, two-slave AXI4-Lite crossbar between the core's data-side LSU master and the memory-mapped peripherals: slave 0 is the main SRAM, slave 1 is the UART. It decodes each address, forwards the transaction to exactly one slave and registers the response back to the master. Unmapped addresses are answered locally with DECERR. Read and write paths are independent, with at most one outstanding transaction per direction.

## Interface
- SRAM_BASE, 32'h8000_0000, slave 0 base address
- SRAM_SIZE, 32'h0800_0000, slave 0 window size in bytes
- UART_BASE, 32'ha000_03f8, slave 1 base address
- UART_SIZE, 32'h0000_0008, slave 1 window size in bytes
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- m_awaddr/m_awvalid/m_awready  in/in/out  32/1/1  master write address
- m_wdata/m_wstrb/m_wvalid/m_wready  in/in/in/out  32/4/1/1  master write data
- m_bresp/m_bvalid/m_bready  out/out/in  2/1/1  master write response
- m_araddr/m_arvalid/m_arready  in/in/out  32/1/1  master read address
- m_rdata/m_rresp/m_rvalid/m_rready  out/out/out/in  32/2/1/1  master read data
- sN_awaddr/sN_awvalid/sN_awready  out/out/in  32/1/1  slave N write address, N=0,1
- sN_wdata/sN_wstrb/sN_wvalid/sN_wready  out/out/out/in  32/4/1/1  slave N write data
- sN_bresp/sN_bvalid/sN_bready  in/in/out  2/1/1  slave N write response
- sN_araddr/sN_arvalid/sN_arready  out/out/in  32/1/1  slave N read address
- sN_rdata/sN_rresp/sN_rvalid/sN_rready  in/in/in/out  32/2/1/1  slave N read data

## Operation
- Decode: slave N hit iff (addr - BASE_N) < SIZE_N, 32-bit unsigned subtraction, so addresses below BASE wrap high and miss. Both hits can never be true (windows are disjoint by construction). No hit -> DECERR.
- Write FSM, states W_IDLE, W_REQ, W_RESP, W_BACK.
  - W_IDLE: m_awready = !aw_got, m_wready = !w_got. AW and W are captured independently, in either order or in the same cycle, into addr/data/strb registers. Once both are held, go to W_REQ on a hit, or to W_BACK with bresp=2'b11 on a miss. No slave is touched on a miss.
  - W_REQ: drive the selected slave only. sN_awvalid stays high until its handshake, sN_wvalid stays high until its handshake, each tracked by a done flag. Go to W_RESP once both are done; both completing in the same cycle is legal.
  - W_RESP: sN_bready=1 for the selected slave. On sN_bvalid, capture bresp and go to W_BACK.
  - W_BACK: m_bvalid=1 with the held bresp. On m_bready, go to W_IDLE and clear aw_got/w_got.
- Read FSM, states R_IDLE, R_REQ, R_RESP, R_BACK.
  - R_IDLE: m_arready=1. On handshake, latch araddr and decode. Hit -> R_REQ. Miss -> R_BACK with rresp=2'b11, rdata=0.
  - R_REQ: sN_arvalid=1 until sN_arready, then R_RESP.
  - R_RESP: sN_rready=1. On sN_rvalid, capture rdata/rresp, then R_BACK.
  - R_BACK: m_rvalid=1. On m_rready, go to R_IDLE.
- Read and write may target the same slave concurrently. There is no ordering between the two directions.
- Unselected slave outputs: valids/readies 0, addr/data driven from the held registers (don't-care).

## Timing
- Reset values: all valid/ready outputs 0 except m_awready=m_wready=m_arready=1; m_bresp=m_rresp=2'b00; m_rdata=0; both FSMs idle.
- Reset asserted mid-transaction aborts immediately: all valids drop asynchronously, held state is cleared, and the in-flight response is discarded. Slaves share the reset domain.
- All outputs are registered or decoded from state. There is no combinational path from any slave input to any master output.
- Minimum write latency, for a slave that is always ready and responds one cycle after accept: AW+W handshake at edge 0, slave valids in cycle 1, slave bvalid in cycle 2, m_bvalid in cycle 3.
- Read latency is the same, with m_rvalid in cycle 3.
- DECERR: m_bvalid/m_rvalid is asserted the cycle after the address handshake (both handshakes for writes).
- m_bvalid/m_rvalid, once set, are held with stable data until the master's ready.

## Structure
- Package axi_lite_pkg holds: RESP_OKAY=2'b00, RESP_DECERR=2'b11, the write-state and read-state enums, and the default address-map constants.
- Sub-module axi_lite_decode, combinational, takes addr and returns {hit0, hit1}. It is instantiated twice (write and read).

## Test plan
- Write to 32'ha000_03f8 with wdata=32'h41, AW and W in the same cycle -> only s1 sees awvalid/wvalid; m_bresp=00 in cycle 3; s0 idle.
- W presented 2 cycles before AW at 32'h8000_0010 -> s0 gets a single write with the correct data and wstrb; one m_bvalid pulse.
- Read from 32'h8000_0000 while s0 returns rdata=32'hdeadbeef with 2 stall cycles on arready -> m_rdata=32'hdeadbeef, rresp=00.
- Write to 32'h0000_0000 and read from 32'hffff_fffc -> bresp=11 and rresp=11 with rdata=0, one cycle after the address handshake; no slave valid ever asserted.
- Concurrent read of the UART and write to SRAM with m_bready held low 5 cycles -> read completes independently; m_bvalid and bresp stay stable until m_bready.
- rst_n pulsed low while in W_RESP -> all valids are 0 immediately; after release the readies return to their reset values and the next write completes normally.
